// File: rtl/reg_file.sv
// Operand register file feeding the 32-bit ALU: two async read ports,
// one sync write port, and a clocked ZF/OF flag register.
module reg_file #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] R_ADDR_A,
  input  logic [ADDR_W-1:0] R_ADDR_B,
  output logic [DATA_W-1:0] R_DATA_A,
  output logic [DATA_W-1:0] R_DATA_B,
  input  logic              WE,
  input  logic [ADDR_W-1:0] W_ADDR,
  input  logic [DATA_W-1:0] W_DATA,
  input  logic              FLAG_WE,
  input  logic              ZF_IN,
  input  logic              OF_IN,
  output logic              ZF,
  output logic              OF
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_zf;
  logic              r_of;
  logic              w_we;

  // Entry 0 is never written, so it stays at its reset value and trims away.
  assign w_we = WE && (W_ADDR != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[W_ADDR] <= W_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_zf <= 1'b0;
      r_of <= 1'b0;
    end else if (FLAG_WE) begin
      r_zf <= ZF_IN;
      r_of <= OF_IN;
    end
  end

  // No write bypass: the ALU may loop R_DATA back into W_DATA.
  assign R_DATA_A = (RST || R_ADDR_A == '0) ? '0 : r_mem[R_ADDR_A];
  assign R_DATA_B = (RST || R_ADDR_B == '0) ? '0 : r_mem[R_ADDR_B];

  assign ZF = r_zf;
  assign OF = r_of;

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file.
// One task per scenario, each with its own inline comparisons.
module tb_reg_file;

  logic        CLK;
  logic        RST;
  logic [4:0]  R_ADDR_A;
  logic [4:0]  R_ADDR_B;
  logic [31:0] R_DATA_A;
  logic [31:0] R_DATA_B;
  logic        WE;
  logic [4:0]  W_ADDR;
  logic [31:0] W_DATA;
  logic        FLAG_WE;
  logic        ZF_IN;
  logic        OF_IN;
  logic        ZF;
  logic        OF;

  int checks;
  int errors;

  reg_file #(.ADDR_W(5), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .R_ADDR_A(R_ADDR_A), .R_ADDR_B(R_ADDR_B),
    .R_DATA_A(R_DATA_A), .R_DATA_B(R_DATA_B),
    .WE(WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .FLAG_WE(FLAG_WE), .ZF_IN(ZF_IN), .OF_IN(OF_IN),
    .ZF(ZF), .OF(OF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    WE = 1'b1; W_ADDR = a; W_DATA = d;
    @(posedge CLK);
    #1;
    WE = 1'b0;
  endtask

  task automatic do_flags(input logic z, input logic o);
    @(negedge CLK);
    FLAG_WE = 1'b1; ZF_IN = z; OF_IN = o;
    @(posedge CLK);
    #1;
    FLAG_WE = 1'b0;
  endtask

  task automatic test_power_on;
    R_ADDR_A = 5'd0; R_ADDR_B = 5'd17;
    #1;
    checks++;
    if (R_DATA_A !== 32'h0 || R_DATA_B !== 32'h0 || ZF !== 1'b0 || OF !== 1'b0) begin
      errors++;
      $display("FAIL power_on: a=%h b=%h zf=%b of=%b expected 0 0 0 0",
               R_DATA_A, R_DATA_B, ZF, OF);
    end
  endtask

  task automatic test_reset;
    do_write(5'd7, 32'hDEAD_BEEF);
    do_write(5'd31, 32'hCAFE_F00D);
    do_flags(1'b1, 1'b1);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    WE = 1'b1; W_ADDR = 5'd9; W_DATA = 32'hA5A5_A5A5;
    FLAG_WE = 1'b1; ZF_IN = 1'b1; OF_IN = 1'b1;
    #1;
    checks++;
    if (ZF !== 1'b0 || OF !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: zf=%b of=%b expected 0 0", ZF, OF);
    end
    for (int i = 0; i < 32; i++) begin
      R_ADDR_A = 5'(i);
      R_ADDR_B = 5'(31 - i);
      #1;
      checks++;
      if (R_DATA_A !== 32'h0 || R_DATA_B !== 32'h0) begin
        errors++;
        $display("FAIL reset_sweep[%0d]: a=%h b=%h expected 0 0",
                 i, R_DATA_A, R_DATA_B);
      end
    end
    @(negedge CLK);
    RST = 1'b0; WE = 1'b0; FLAG_WE = 1'b0;
    R_ADDR_A = 5'd9; R_ADDR_B = 5'd7;
    #1;
    checks++;
    if (R_DATA_A !== 32'h0 || R_DATA_B !== 32'h0 || ZF !== 1'b0 || OF !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignore: r9=%h r7=%h zf=%b of=%b expected 0 0 0 0",
               R_DATA_A, R_DATA_B, ZF, OF);
    end
  endtask

  task automatic test_basic;
    do_write(5'd1, 32'h1234_5678);
    do_write(5'd2, 32'h3333_2222);
    R_ADDR_A = 5'd1; R_ADDR_B = 5'd2;
    #1;
    checks++;
    if (R_DATA_A !== 32'h1234_5678 || R_DATA_B !== 32'h3333_2222) begin
      errors++;
      $display("FAIL basic: a=%h b=%h expected 12345678 33332222",
               R_DATA_A, R_DATA_B);
    end
    do_write(5'd31, 32'h8000_0001);
    do_write(5'd16, 32'hFFFF_0000);
    R_ADDR_A = 5'd31; R_ADDR_B = 5'd16;
    #1;
    checks++;
    if (R_DATA_A !== 32'h8000_0001 || R_DATA_B !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL bit_exact: a=%h b=%h expected 80000001 ffff0000",
               R_DATA_A, R_DATA_B);
    end
    R_ADDR_A = 5'd16; R_ADDR_B = 5'd16;
    #1;
    checks++;
    if (R_DATA_A !== 32'hFFFF_0000 || R_DATA_B !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL dual_read: a=%h b=%h expected ffff0000 ffff0000",
               R_DATA_A, R_DATA_B);
    end
  endtask

  task automatic test_we_low;
    @(negedge CLK);
    WE = 1'b0; W_ADDR = 5'd1; W_DATA = 32'h0BAD_0BAD;
    @(posedge CLK);
    #1;
    R_ADDR_A = 5'd1; R_ADDR_B = 5'd2;
    #1;
    checks++;
    if (R_DATA_A !== 32'h1234_5678 || R_DATA_B !== 32'h3333_2222) begin
      errors++;
      $display("FAIL we_low: a=%h b=%h expected 12345678 33332222",
               R_DATA_A, R_DATA_B);
    end
  endtask

  task automatic test_r0;
    do_write(5'd0, 32'hFFFF_FFFF);
    R_ADDR_A = 5'd0; R_ADDR_B = 5'd0;
    #1;
    checks++;
    if (R_DATA_A !== 32'h0 || R_DATA_B !== 32'h0) begin
      errors++;
      $display("FAIL r0: a=%h b=%h expected 0 0", R_DATA_A, R_DATA_B);
    end
  endtask

  task automatic test_rdw;
    do_write(5'd3, 32'h7FFF_FFFF);
    @(negedge CLK);
    R_ADDR_A = 5'd3;
    WE = 1'b1; W_ADDR = 5'd3; W_DATA = 32'h8000_0000;
    #1;
    checks++;
    if (R_DATA_A !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL rdw_old: a=%h expected 7fffffff", R_DATA_A);
    end
    @(posedge CLK);
    #1;
    WE = 1'b0;
    checks++;
    if (R_DATA_A !== 32'h8000_0000) begin
      errors++;
      $display("FAIL rdw_new: a=%h expected 80000000", R_DATA_A);
    end
  endtask

  task automatic test_flags;
    do_flags(1'b1, 1'b1);
    checks++;
    if (ZF !== 1'b1 || OF !== 1'b1) begin
      errors++;
      $display("FAIL flags_set: zf=%b of=%b expected 1 1", ZF, OF);
    end
    @(negedge CLK);
    FLAG_WE = 1'b0; ZF_IN = 1'b0; OF_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (ZF !== 1'b1 || OF !== 1'b1) begin
        errors++;
        $display("FAIL flags_hold[%0d]: zf=%b of=%b expected 1 1", i, ZF, OF);
      end
    end
    do_flags(1'b0, 1'b1);
    checks++;
    if (ZF !== 1'b0 || OF !== 1'b1) begin
      errors++;
      $display("FAIL flags_split: zf=%b of=%b expected 0 1", ZF, OF);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge CLK);
    WE = 1'b1; W_ADDR = 5'd10; W_DATA = 32'h0000_00AA;
    FLAG_WE = 1'b1; ZF_IN = 1'b1; OF_IN = 1'b0;
    @(posedge CLK);
    #1;
    W_ADDR = 5'd11; W_DATA = 32'h0000_00BB;
    FLAG_WE = 1'b0;
    @(posedge CLK);
    #1;
    WE = 1'b0;
    R_ADDR_A = 5'd10; R_ADDR_B = 5'd11;
    #1;
    checks++;
    if (R_DATA_A !== 32'h0000_00AA || R_DATA_B !== 32'h0000_00BB ||
        ZF !== 1'b1 || OF !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: a=%h b=%h zf=%b of=%b expected aa bb 1 0",
               R_DATA_A, R_DATA_B, ZF, OF);
    end
  endtask

  task automatic test_reset_mid_write;
    do_write(5'd5, 32'h9ABC_DEF0);
    R_ADDR_A = 5'd5;
    #1;
    checks++;
    if (R_DATA_A !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL mid_pre: a=%h expected 9abcdef0", R_DATA_A);
    end
    @(negedge CLK);
    WE = 1'b1; W_ADDR = 5'd5; W_DATA = 32'h1111_2222;
    #3;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0; WE = 1'b0;
    #1;
    checks++;
    if (R_DATA_A !== 32'h0) begin
      errors++;
      $display("FAIL mid_write: a=%h expected 0", R_DATA_A);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    RST = 1'b1;
    WE = 1'b0; W_ADDR = '0; W_DATA = '0;
    FLAG_WE = 1'b0; ZF_IN = 1'b0; OF_IN = 1'b0;
    R_ADDR_A = '0; R_ADDR_B = '0;
    test_power_on();
    @(negedge CLK);
    RST = 1'b0;
    test_reset();
    test_basic();
    test_we_low();
    test_r0();
    test_rdw();
    test_flags();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
